decaimiento_mascota: RTL and testbench

DECAIMIENTO_MASCOTA -- requirements
Module: decaimiento_mascota

---
 rtl/decaimiento_mascota.sv | 190 +++++++++++++++++++
 tb/tb_decaimiento_mascota.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decaimiento_mascota.sv
// -----------------------------------------------------------------------------
// decaimiento_mascota
//   Virtual-pet stat decay engine. Hambre, diversion and energia (0-7, 7 best)
//   decay on second ticks derived from the time-of-day counter. The pet sleeps
//   on request or at night and recovers energia while asleep. It dies after
//   T_MUERTE consecutive ticks with hambre at 0, and stays dead until reset.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   sec [5:0]      seconds from time-of-day counter (0-59)
//   hour [4:0]     hours from time-of-day counter (0-23)
//   btn_alimentar  one-cycle feed pulse
//   btn_jugar      one-cycle play pulse
//   btn_dormir     one-cycle sleep-toggle pulse
//   hambre [2:0]   hunger stat
//   energia [2:0]  energy stat
//   diversion [2:0] fun stat
//   estado [1:0]   00 AWAKE, 01 SLEEP, 10 DEAD
//   alerta         attention flag, registered from the current stats
// -----------------------------------------------------------------------------
module decaimiento_mascota #(
    parameter int T_HAMBRE    = 10,
    parameter int T_DIVERSION = 15,
    parameter int T_ENERGIA   = 20,
    parameter int T_DESCANSO  = 5,
    parameter int T_MUERTE    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [4:0] hour,
    input  logic       btn_alimentar,
    input  logic       btn_jugar,
    input  logic       btn_dormir,
    output logic [2:0] hambre,
    output logic [2:0] energia,
    output logic [2:0] diversion,
    output logic [1:0] estado,
    output logic       alerta
);

    typedef enum logic [1:0] {
        AWAKE = 2'b00,
        SLEEP = 2'b01,
        DEAD  = 2'b10
    } estado_t;

    // Last count value of each phase counter; reaching it wraps and fires.
    localparam logic [7:0] H_LAST = 8'(T_HAMBRE - 1);
    localparam logic [7:0] D_LAST = 8'(T_DIVERSION - 1);
    localparam logic [7:0] E_LAST = 8'(T_ENERGIA - 1);
    localparam logic [7:0] S_LAST = 8'(T_DESCANSO - 1);
    localparam logic [7:0] M_LAST = 8'(T_MUERTE - 1);

    estado_t    st, st_n;
    logic [5:0] sec_prev;
    logic [7:0] ph_h, ph_d, ph_e, ph_s, starv;
    logic [7:0] ph_h_n, ph_d_n, ph_e_n, ph_s_n, starv_n;
    logic [2:0] hambre_n, energia_n, diversion_n;
    logic       alerta_n;
    logic       tick, night;

    assign tick   = (sec != sec_prev);
    assign night  = (hour >= 5'd22) || (hour < 5'd6);
    assign estado = st;

    function automatic logic [2:0] sat_dec(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    function automatic logic [2:0] sat_add(input logic [2:0] v, input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, v} + {1'b0, k};
        return (s > 4'd7) ? 3'd7 : s[2:0];
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        st_n        = st;
        hambre_n    = hambre;
        energia_n   = energia;
        diversion_n = diversion;
        ph_h_n      = ph_h;
        ph_d_n      = ph_d;
        ph_e_n      = ph_e;
        ph_s_n      = ph_s;
        starv_n     = starv;

        unique case (st)
            AWAKE: begin
                if (tick) begin
                    if (ph_h == H_LAST) begin
                        ph_h_n   = '0;
                        hambre_n = sat_dec(hambre);
                    end else begin
                        ph_h_n = ph_h + 8'd1;
                    end
                    if (ph_d == D_LAST) begin
                        ph_d_n      = '0;
                        diversion_n = sat_dec(diversion);
                    end else begin
                        ph_d_n = ph_d + 8'd1;
                    end
                    if (ph_e == E_LAST) begin
                        ph_e_n    = '0;
                        energia_n = sat_dec(energia);
                    end else begin
                        ph_e_n = ph_e + 8'd1;
                    end
                end
                // Buttons act on the already-decayed values.
                if (btn_alimentar) hambre_n = sat_add(hambre_n, 3'd2);
                if (btn_jugar) begin
                    diversion_n = sat_add(diversion_n, 3'd2);
                    energia_n   = sat_dec(energia_n);
                end
                if (btn_dormir || night) st_n = SLEEP;
            end
            SLEEP: begin
                if (tick) begin
                    if (ph_h == H_LAST) begin
                        ph_h_n   = '0;
                        hambre_n = sat_dec(hambre);
                    end else begin
                        ph_h_n = ph_h + 8'd1;
                    end
                    if (ph_s == S_LAST) begin
                        ph_s_n    = '0;
                        energia_n = sat_add(energia, 3'd1);
                    end else begin
                        ph_s_n = ph_s + 8'd1;
                    end
                end
                if (!night && (energia == 3'd7 || btn_dormir)) begin
                    st_n   = AWAKE;
                    ph_s_n = '0;
                end
            end
            DEAD: ;
            default: st_n = AWAKE;
        endcase

        // Starvation only accumulates while hambre stays at 0 across the
        // update; a feed that lifts it off 0 clears the count immediately.
        // Death overrides whatever transition was chosen above.
        if (st == AWAKE || st == SLEEP) begin
            if (hambre != 3'd0 || hambre_n != 3'd0) begin
                starv_n = '0;
            end else if (tick) begin
                starv_n = starv + 8'd1;
                if (starv == M_LAST) st_n = DEAD;
            end
        end

        alerta_n = (st == DEAD) || (hambre <= 3'd2) ||
                   (energia <= 3'd2) || (diversion <= 3'd2);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        sec_prev <= sec;
        if (rst) begin
            st        <= AWAKE;
            hambre    <= 3'd7;
            energia   <= 3'd7;
            diversion <= 3'd7;
            alerta    <= 1'b0;
            ph_h      <= '0;
            ph_d      <= '0;
            ph_e      <= '0;
            ph_s      <= '0;
            starv     <= '0;
        end else begin
            st        <= st_n;
            hambre    <= hambre_n;
            energia   <= energia_n;
            diversion <= diversion_n;
            alerta    <= alerta_n;
            ph_h      <= ph_h_n;
            ph_d      <= ph_d_n;
            ph_e      <= ph_e_n;
            ph_s      <= ph_s_n;
            starv     <= starv_n;
        end
    end

endmodule

// File: tb/tb_decaimiento_mascota.sv
// -----------------------------------------------------------------------------
// tb_decaimiento_mascota
//   Directed and randomized stimulus for decaimiento_mascota. A behavioural
//   model (plain integers, tick counts toward each stat event) predicts every
//   output after each clock edge; outputs are sampled 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_decaimiento_mascota;

    localparam int T_HAMBRE    = 10;
    localparam int T_DIVERSION = 15;
    localparam int T_ENERGIA   = 20;
    localparam int T_DESCANSO  = 5;
    localparam int T_MUERTE    = 10;

    logic       clk;
    logic       rst;
    logic [5:0] sec;
    logic [4:0] hour;
    logic       btn_alimentar, btn_jugar, btn_dormir;
    logic [2:0] hambre, energia, diversion;
    logic [1:0] estado;
    logic       alerta;

    decaimiento_mascota #(
        .T_HAMBRE   (T_HAMBRE),
        .T_DIVERSION(T_DIVERSION),
        .T_ENERGIA  (T_ENERGIA),
        .T_DESCANSO (T_DESCANSO),
        .T_MUERTE   (T_MUERTE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sec          (sec),
        .hour         (hour),
        .btn_alimentar(btn_alimentar),
        .btn_jugar    (btn_jugar),
        .btn_dormir   (btn_dormir),
        .hambre       (hambre),
        .energia      (energia),
        .diversion    (diversion),
        .estado       (estado),
        .alerta       (alerta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: stats, state code (0 awake, 1 sleep, 2 dead), flag, and
    // how many ticks have elapsed toward each periodic event.
    int         m_h, m_d, m_e, m_st, m_al;
    int         n_h, n_d, n_e, n_s, n_starv;
    logic [5:0] m_prev;

    function automatic int lim7(int v);
        return (v > 7) ? 7 : v;
    endfunction

    function automatic int lim0(int v);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit tk, nt;
        int oh, od, oe, ost;
        tk     = (sec != m_prev);
        m_prev = sec;
        if (rst) begin
            m_h = 7; m_d = 7; m_e = 7; m_st = 0; m_al = 0;
            n_h = 0; n_d = 0; n_e = 0; n_s = 0; n_starv = 0;
            return;
        end
        oh = m_h; od = m_d; oe = m_e; ost = m_st;
        nt = (hour >= 22) || (hour < 6);
        m_al = (ost == 2 || oh <= 2 || od <= 2 || oe <= 2) ? 1 : 0;
        if (ost == 0) begin
            if (tk) begin
                n_h++; if (n_h == T_HAMBRE)    begin n_h = 0; m_h = lim0(m_h - 1); end
                n_d++; if (n_d == T_DIVERSION) begin n_d = 0; m_d = lim0(m_d - 1); end
                n_e++; if (n_e == T_ENERGIA)   begin n_e = 0; m_e = lim0(m_e - 1); end
            end
            if (btn_alimentar) m_h = lim7(m_h + 2);
            if (btn_jugar) begin
                m_d = lim7(m_d + 2);
                m_e = lim0(m_e - 1);
            end
            if (btn_dormir || nt) m_st = 1;
        end else if (ost == 1) begin
            if (tk) begin
                n_h++; if (n_h == T_HAMBRE)   begin n_h = 0; m_h = lim0(m_h - 1); end
                n_s++; if (n_s == T_DESCANSO) begin n_s = 0; m_e = lim7(m_e + 1); end
            end
            if (!nt && (oe == 7 || btn_dormir)) begin
                m_st = 0;
                n_s  = 0;
            end
        end
        if (ost != 2) begin
            if (oh == 0 && m_h == 0) begin
                if (tk) begin
                    n_starv++;
                    if (n_starv == T_MUERTE) m_st = 2;
                end
            end else begin
                n_starv = 0;
            end
        end
    endtask

    // One clock: predict, let the edge happen, compare all outputs.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("hambre",    {29'd0, hambre},    m_h);
        check("diversion", {29'd0, diversion}, m_d);
        check("energia",   {29'd0, energia},   m_e);
        check("estado",    {30'd0, estado},    m_st);
        check("alerta",    {31'd0, alerta},    m_al);
    endtask

    // Advance sec by one (a tick) with the given button pulses for one cycle.
    task automatic tick_step(input logic f, input logic p, input logic s);
        sec           = 6'((int'(sec) + 1) % 60);
        btn_alimentar = f;
        btn_jugar     = p;
        btn_dormir    = s;
        step();
        btn_alimentar = 1'b0;
        btn_jugar     = 1'b0;
        btn_dormir    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sec = 6'd0; hour = 5'd12;
        btn_alimentar = 1'b0; btn_jugar = 1'b0; btn_dormir = 1'b0;
        m_prev = 6'd0;

        // Reset state.
        step();
        check("rst_hambre", {29'd0, hambre}, 7);
        check("rst_estado", {30'd0, estado}, 0);
        check("rst_alerta", {31'd0, alerta}, 0);
        rst = 1'b0;
        step();

        // Ten ticks at noon: hambre drops once on the tenth.
        for (int i = 0; i < 9; i++) tick_step(1'b0, 1'b0, 1'b0);
        check("pre10_hambre", {29'd0, hambre}, 7);
        tick_step(1'b0, 1'b0, 1'b0);
        check("t10_hambre",    {29'd0, hambre},    6);
        check("t10_diversion", {29'd0, diversion}, 7);
        check("t10_energia",   {29'd0, energia},   7);

        // Constant sec: no ticks for 1000 cycles; then 59 -> 0 wrap.
        for (int i = 0; i < 1000; i++) step();
        check("hold_hambre", {29'd0, hambre}, 6);
        sec = 6'd59;
        step();
        sec = 6'd0;
        step();
        for (int i = 0; i < 3; i++) step();

        // Starve to 0 and feed on the exact decay tick that would kill.
        for (int i = 0; i < 300 && !(m_h == 0 && n_h == T_HAMBRE - 1); i++)
            tick_step(1'b0, 1'b0, 1'b0);
        check("starve_hambre0", {29'd0, hambre}, 0);
        tick_step(1'b1, 1'b0, 1'b0);
        check("feed_decay_hambre", {29'd0, hambre}, 2);
        check("feed_decay_alive",  {30'd0, estado}, 0);
        for (int i = 0; i < 3; i++) tick_step(1'b1, 1'b0, 1'b0);
        check("feed_sat_hambre", {29'd0, hambre}, 7);

        // Nightfall puts the pet to sleep; play is ignored while asleep.
        hour = 5'd21;
        step();
        check("dusk_awake", {30'd0, estado}, 0);
        hour = 5'd22;
        step();
        check("night_sleep", {30'd0, estado}, 1);
        for (int i = 0; i < 12; i++) tick_step(1'b0, 1'(i % 2), 1'b0);

        // Morning: wake once energia has recovered to 7.
        hour = 5'd7;
        for (int i = 0; i < 200 && m_st != 0; i++) tick_step(1'b0, 1'b0, 1'b0);
        check("morning_awake",  {30'd0, estado},  0);
        check("morning_energia", {29'd0, energia}, 7);
        for (int i = 0; i < 6; i++) tick_step(1'b0, 1'b0, 1'b0);

        // Randomized operation against the model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) hour = 5'($urandom_range(0, 23));
            if ($urandom_range(0, 1) == 1)
                sec = 6'((int'(sec) + int'($urandom_range(1, 3))) % 60);
            btn_alimentar = ($urandom_range(0, 7) == 0);
            btn_jugar     = ($urandom_range(0, 7) == 0);
            btn_dormir    = ($urandom_range(0, 15) == 0);
            step();
        end
        btn_alimentar = 1'b0; btn_jugar = 1'b0; btn_dormir = 1'b0;

        // Starvation death, sticky and frozen, then reset out of DEAD.
        rst  = 1'b1;
        hour = 5'd12;
        step();
        rst = 1'b0;
        for (int i = 0; i < 400 && m_st != 2; i++) tick_step(1'b0, 1'b0, 1'b0);
        check("dead_estado", {30'd0, estado}, 2);
        step();
        check("dead_alerta", {31'd0, alerta}, 1);
        hour = 5'd23;
        for (int i = 0; i < 20; i++)
            tick_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("dead_sticky", {30'd0, estado}, 2);
        check("dead_frozen_hambre", {29'd0, hambre}, 0);
        rst = 1'b1;
        btn_alimentar = 1'b1; btn_jugar = 1'b1; btn_dormir = 1'b1;
        sec = 6'((int'(sec) + 1) % 60);
        step();
        check("rst_dead_hambre",    {29'd0, hambre},    7);
        check("rst_dead_energia",   {29'd0, energia},   7);
        check("rst_dead_diversion", {29'd0, diversion}, 7);
        check("rst_dead_estado",    {30'd0, estado},    0);
        check("rst_dead_alerta",    {31'd0, alerta},    0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
